// File: rtl/shift_pkg.sv
// Shared types and helpers for the sequential left shifter.
//   shl_state_t : FSM encoding (IDLE, SHIFT, DONE)
//   sat_count   : clamps a requested shift amount to the operand width
package shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } shl_state_t;

  // Any amount at or beyond the operand width clears every bit. Clamping here
  // lets the down-counter be only wide enough to hold n.
  function automatic int unsigned sat_count(input int unsigned amt,
                                            input int unsigned n);
    return (amt > n) ? n : amt;
  endfunction

endpackage

// File: rtl/shift_counter.sv
// Loadable down-counter for the shift-step count.
//   clk, rst  : clock, synchronous active-high reset (clears value)
//   load      : load value <= load_val (has priority over dec)
//   load_val  : value to load
//   dec       : decrement by one; ignored when already zero
//   value     : current count
//   zero      : value == 0
module shift_counter #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic [CW-1:0] value,
  output logic          zero
);

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (dec && (value != '0)) begin
      value <= value - CW'(1);
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/shift_left_seq.sv
// Sequential logical left shifter: one bit per clock under a start/done
// handshake.
//   clk        : system clock
//   rst        : synchronous active-high reset; aborts any operation in flight
//   start      : request, sampled only while IDLE
//   a          : operand, captured on accepted start
//   aDesplace  : unsigned shift amount, captured on accepted start (>= N saturates)
//   result     : shifted value, valid with done and held until the next accepted start
//   sign       : result[N-1]
//   overflow   : a 1 bit left position N-1 at some point of the operation
//   busy       : high in SHIFT and DONE
//   done       : single-cycle completion pulse
module shift_left_seq
  import shift_pkg::*;
#(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] aDesplace,
  output logic [N-1:0] result,
  output logic         sign,
  output logic         overflow,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(N + 1);

  shl_state_t    state, state_nxt;
  logic [N-1:0]  shreg;
  logic          ovf_q;
  logic          load_en;
  logic          shift_en;
  logic [CW-1:0] cnt_init;
  logic [CW-1:0] cnt_value;
  logic          cnt_zero;

  // Clamp before loading so the counter never needs more than CW bits.
  assign cnt_init = CW'(sat_count(32'(aDesplace), N));

  shift_counter #(.CW(CW)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (load_en),
    .load_val (cnt_init),
    .dec      (shift_en),
    .value    (cnt_value),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Starts arriving in SHIFT or DONE are dropped, not queued: only IDLE looks at start.
  always_comb begin
    state_nxt = state;
    load_en   = 1'b0;
    shift_en  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load_en   = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (!cnt_zero) begin
          shift_en = 1'b1;
        end else begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Shift register and sticky overflow; both cleared by reset so an aborted
  // operation leaves nothing behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '0;
      ovf_q <= 1'b0;
    end else if (load_en) begin
      shreg <= a;
      ovf_q <= 1'b0;
    end else if (shift_en) begin
      shreg <= {shreg[N-2:0], 1'b0};
      ovf_q <= ovf_q | shreg[N-1];
    end
  end

  assign result   = shreg;
  assign sign     = shreg[N-1];
  assign overflow = ovf_q;
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

endmodule

// File: tb/tb_shift_left_seq.sv
`timescale 1ns/1ps
module tb_shift_left_seq;

  localparam int N = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] aDesplace = '0;
  logic [N-1:0] result;
  logic         sign, overflow, busy, done;

  int total = 0;
  int bad   = 0;

  shift_left_seq #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .aDesplace (aDesplace),
    .result    (result),
    .sign      (sign),
    .overflow  (overflow),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] amt;
    int           lat;
    logic [N-1:0] res;
    logic         sgn;
    logic         ovf;
  } vec_t;

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Launch one operation and follow it to done. Inputs are scrambled right
  // after acceptance so only the captured values may influence the result.
  task automatic run_op(input string tag, input vec_t v);
    int lat;
    lat = 0;
    @(negedge clk);
    a = v.a; aDesplace = v.amt; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = ~v.a; aDesplace = ~v.amt;
    check({tag, " busy after accept"}, int'(busy), 1);
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    check({tag, " latency"}, lat, v.lat);
    check({tag, " result"}, int'(result), int'(v.res));
    check({tag, " sign"}, int'(sign), int'(v.sgn));
    check({tag, " overflow"}, int'(overflow), int'(v.ovf));
    @(posedge clk); #1;
    check({tag, " done one cycle"}, int'(done), 0);
    check({tag, " idle after done"}, int'(busy), 0);
    check({tag, " result held"}, int'(result), int'(v.res));
  endtask

  vec_t vecs[8];
  int   ndone;

  initial begin
    vecs[0] = '{5'b01011, 5'd1,  2, 5'b10110, 1'b1, 1'b0};
    vecs[1] = '{5'b01011, 5'd2,  3, 5'b01100, 1'b0, 1'b1};
    vecs[2] = '{5'b10101, 5'd0,  1, 5'b10101, 1'b1, 1'b0};
    vecs[3] = '{5'b11111, 5'd7,  6, 5'b00000, 1'b0, 1'b1};
    vecs[4] = '{5'b00001, 5'd4,  5, 5'b10000, 1'b1, 1'b0};
    vecs[5] = '{5'b10000, 5'd1,  2, 5'b00000, 1'b0, 1'b1};
    vecs[6] = '{5'b00001, 5'd5,  6, 5'b00000, 1'b0, 1'b1};
    vecs[7] = '{5'b00000, 5'd31, 6, 5'b00000, 1'b0, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset result", int'(result), 0);
    check("reset sign", int'(sign), 0);
    check("reset overflow", int'(overflow), 0);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i]);
    end

    // Start pulse while busy must be ignored
    @(negedge clk);
    a = 5'b00011; aDesplace = 5'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 5'b11111; aDesplace = 5'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        check("busy-start result", int'(result), int'(5'b11000));
        check("busy-start overflow", int'(overflow), 0);
        check("busy-start sign", int'(sign), 1);
      end
    end
    check("busy-start done pulses", ndone, 1);

    // Reset in the middle of an operation
    @(negedge clk);
    a = 5'b01011; aDesplace = 5'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre-reset busy", int'(busy), 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort busy", int'(busy), 0);
    check("abort done", int'(done), 0);
    check("abort result", int'(result), 0);
    check("abort overflow", int'(overflow), 0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("abort no done", ndone, 0);
    run_op("after-abort", vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
